// File: rtl/sda_kernel_param_pkg.sv
// Shared constants and helpers for the kernel parameter-port arbiter.
package sda_kernel_param_pkg;

   localparam int ParamDataWidth = 32;
   localparam int MaxNumPorts    = 8;

   // A tag must be able to name every requester, and is never narrower than one bit.
   function automatic int tagWidthOf(input int numPorts);
      return (numPorts <= 2) ? 1 : $clog2(numPorts);
   endfunction

endpackage

// File: rtl/sda_param_tag_fifo.sv
// In-order tag FIFO recording which requester issued each outstanding parameter read.
module sda_param_tag_fifo #(
   parameter int TagWidth = 2,
   parameter int TagDepth = 8
) (
   input  logic                clk,
   input  logic                srst,
   input  logic                push,
   input  logic [TagWidth-1:0] pushTag,
   input  logic                pop,
   output logic                full,
   output logic                empty,
   output logic [TagWidth-1:0] head
);

   localparam int PtrWidth = $clog2(TagDepth);

   logic [PtrWidth-1:0] wrPtr_q;
   logic [PtrWidth-1:0] rdPtr_q;
   logic [PtrWidth:0]   count_q;
   logic [TagWidth-1:0] mem_q [TagDepth];
   logic                doPush;
   logic                doPop;

   assign full   = (count_q == (PtrWidth+1)'(TagDepth));
   assign empty  = (count_q == '0);
   assign doPush = push & ~full;
   assign doPop  = pop & ~empty;
   assign head   = mem_q[rdPtr_q];

   // Depth is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (srst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
         for (int i = 0; i < TagDepth; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (doPush) begin
            mem_q[wrPtr_q] <= pushTag;
            wrPtr_q        <= wrPtr_q + 1'b1;
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/sda_kernel_param_arbiter.sv
// Round-robin sharing of the parameter RAM read port; a tag FIFO steers in-order read data back.
module sda_kernel_param_arbiter
   import sda_kernel_param_pkg::*;
#(
   parameter int NumPorts = 4,
   parameter int TagDepth = 8,
   parameter int TagWidth = tagWidthOf(NumPorts)
) (
   input  logic                               clk,
   input  logic                               srst,
   input  logic [NumPorts-1:0]                reqAddrValid,
   input  logic [NumPorts*ParamDataWidth-1:0] reqAddr,
   output logic [NumPorts-1:0]                reqAddrStop,
   output logic [NumPorts-1:0]                respDataValid,
   output logic [NumPorts*ParamDataWidth-1:0] respData,
   input  logic [NumPorts-1:0]                respDataStop,
   output logic                               paramAddrValid,
   output logic [ParamDataWidth-1:0]          paramAddr,
   input  logic                               paramAddrStop,
   input  logic                               paramDataValid,
   input  logic [ParamDataWidth-1:0]          paramData,
   output logic                               paramDataStop,
   output logic                               protocolErr
);

   logic                      addrValid_q;
   logic [ParamDataWidth-1:0] addr_q;
   logic [TagWidth-1:0]       rrPtr_q;
   logic                      protocolErr_q;

   logic                      stageFree;
   logic                      anyValid;
   logic [TagWidth-1:0]       winner;
   logic [ParamDataWidth-1:0] winnerAddr;
   logic                      load;
   logic                      tagFull;
   logic                      tagEmpty;
   logic [TagWidth-1:0]       tagHead;
   logic                      tagPop;
   int                        idx;

   assign stageFree = ~addrValid_q | ~paramAddrStop;

   // Scan downward so the lowest offset from rrPtr_q is the one left standing.
   always_comb begin
      anyValid   = 1'b0;
      winner     = '0;
      winnerAddr = '0;
      idx        = 0;
      for (int k = NumPorts - 1; k >= 0; k--) begin
         idx = (int'(rrPtr_q) + k) % NumPorts;
         if (reqAddrValid[idx]) begin
            anyValid   = 1'b1;
            winner     = TagWidth'(idx);
            winnerAddr = reqAddr[ParamDataWidth*idx +: ParamDataWidth];
         end
      end
   end

   // Suppressing load during srst keeps every requester stopped while reset is held.
   assign load = ~srst & stageFree & ~tagFull & anyValid;

   always_comb begin
      reqAddrStop = '1;
      for (int i = 0; i < NumPorts; i++) begin
         if (load && (int'(winner) == i)) begin
            reqAddrStop[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         addrValid_q <= 1'b0;
         addr_q      <= '0;
         rrPtr_q     <= '0;
      end else if (load) begin
         addrValid_q <= 1'b1;
         addr_q      <= winnerAddr;
         rrPtr_q     <= (int'(winner) == NumPorts - 1) ? '0 : winner + 1'b1;
      end else if (stageFree) begin
         addrValid_q <= 1'b0;
      end
   end

   assign paramAddrValid = addrValid_q;
   assign paramAddr      = addr_q;

   sda_param_tag_fifo #(
      .TagWidth (TagWidth),
      .TagDepth (TagDepth)
   ) u_tagFifo (
      .clk     (clk),
      .srst    (srst),
      .push    (load),
      .pushTag (winner),
      .pop     (tagPop),
      .full    (tagFull),
      .empty   (tagEmpty),
      .head    (tagHead)
   );

   // A stalled head requester blocks everyone behind it; read data is strictly in issue order.
   assign paramDataStop = tagEmpty | respDataStop[tagHead];
   assign tagPop        = paramDataValid & ~paramDataStop;

   always_comb begin
      respDataValid = '0;
      respData      = '0;
      for (int i = 0; i < NumPorts; i++) begin
         if (int'(tagHead) == i) begin
            respDataValid[i]                             = paramDataValid & ~tagEmpty;
            respData[ParamDataWidth*i +: ParamDataWidth] = paramData;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         protocolErr_q <= 1'b0;
      end else if (paramDataValid && tagEmpty) begin
         protocolErr_q <= 1'b1;
      end
   end

   assign protocolErr = protocolErr_q;

endmodule
